// File: rtl/conv_matrix_loader.sv
// Byte-stream loader that packs a pixel region and a kernel into 5x5-layout buses for the
// convolution datapath. Optional kernel reuse is enabled by defining CONV_KERNEL_HOLD_EN.
module conv_matrix_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   size_in,
  input  logic         keep_kernel,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] matrix_a,
  output logic [199:0] matrix_b,
  output logic [1:0]   matrix_size,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         err_start
);

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StPresent} state_e;

  state_e         state_q, state_d;
  logic [1:0]     size_q, size_d;
  logic [2:0]     row_q, row_d, col_q, col_d;
  logic [199:0]   mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic           err_q, err_d;
  logic           hold_q, hold_d;
  logic           hold_now;
  logic           beat, last_beat, start_acc;
  logic [2:0]     last_idx;
  logic [4:0]     elem;
  logic [7:0]     base;

  assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
  assign beat      = in_valid && in_ready;
  assign last_idx  = {1'b0, size_q} + 3'd1;
  assign last_beat = beat && (row_q == last_idx) && (col_q == last_idx);
  assign start_acc = start && (state_q == StIdle);
  assign elem      = ({2'b00, row_q} * 5'd5) + {2'b00, col_q};
  assign base      = {elem, 3'b000};

`ifdef CONV_KERNEL_HOLD_EN
  logic       kernel_loaded_q;
  logic [1:0] kernel_size_q;

  assign hold_now = keep_kernel && kernel_loaded_q && (size_in == kernel_size_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_loaded_q <= 1'b0;
      kernel_size_q   <= 2'b00;
    end else if (start_acc && !hold_now) begin
      // matrix_b is about to be cleared, so the stored kernel is gone
      kernel_loaded_q <= 1'b0;
    end else if (state_q == StLoadB && last_beat) begin
      kernel_loaded_q <= 1'b1;
      kernel_size_q   <= size_q;
    end
  end
`else
  logic unused_keep_kernel;
  assign unused_keep_kernel = keep_kernel;
  assign hold_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    row_d   = row_q;
    col_d   = col_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    hold_d  = hold_q;
    err_d   = start && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          size_d  = size_in;
          mat_a_d = '0;
          if (!hold_now) mat_b_d = '0;
          hold_d  = hold_now;
          row_d   = 3'd0;
          col_d   = 3'd0;
          state_d = StLoadA;
        end
      end
      StLoadA, StLoadB: begin
        if (beat) begin
          if (state_q == StLoadA) mat_a_d[base +: 8] = in_data;
          else                    mat_b_d[base +: 8] = in_data;
          if (col_q == last_idx) begin
            col_d = 3'd0;
            if (row_q == last_idx) begin
              row_d = 3'd0;
              if (state_q == StLoadA) state_d = hold_q ? StPresent : StLoadB;
              else                    state_d = StPresent;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      StPresent: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      size_q  <= 2'b00;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign matrix_a    = mat_a_q;
  assign matrix_b    = mat_b_q;
  assign matrix_size = size_q;
  assign out_valid   = (state_q == StPresent);
  assign busy        = (state_q != StIdle);
  assign err_start   = err_q;

endmodule

// File: tb/tb_conv_matrix_loader.sv
// Directed bench for conv_matrix_loader; expected buses are queued when a load is driven and
// popped when out_valid appears. Define CONV_KERNEL_HOLD_EN to also exercise kernel reuse.
module tb_conv_matrix_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   size_in = 2'b00;
  logic         keep_kernel = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [199:0] matrix_a, matrix_b;
  logic [1:0]   matrix_size;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         err_start;

  conv_matrix_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size_in(size_in), .keep_kernel(keep_kernel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .matrix_a(matrix_a),
    .matrix_b(matrix_b), .matrix_size(matrix_size), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .err_start(err_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [199:0] a;
    logic [199:0] b;
    logic [1:0]   sz;
  } exp_t;

  exp_t         sb[$];
  logic [199:0] last_b = '0;
  int           vectors = 0;
  int           miscompares = 0;
  int           cycle = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string tag, input logic [405:0] obs, input logic [405:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int k, input int nn, input int a_seed,
                                         input int a_step, input int b_seed, input int b_step);
    int v;
    v = (k < nn) ? a_seed + k * a_step : b_seed + (k - nn) * b_step;
    return v[7:0];
  endfunction

  // One complete load: start, stream bytes, hold in PRESENT for hold_cyc cycles, handshake.
  task automatic load(input logic [1:0] sz, input int a_seed, input int a_step,
                      input int b_seed, input int b_step, input bit toggle, input bit keep,
                      input bit held, input int hold_cyc, input bit err_b, input bit err_hs);
    int   n, nn, total, k, budget, t0;
    bit   v, rdy, pulsed, pulse_now;
    exp_t e, got;
    n  = int'(sz) + 2;
    nn = n * n;
    total = held ? nn : 2 * nn;
    e.a = '0;
    e.b = held ? last_b : '0;
    e.sz = sz;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        e.a[(r*5+c)*8 +: 8] = byte_at(r*n+c, nn, a_seed, a_step, b_seed, b_step);
        if (!held) e.b[(r*5+c)*8 +: 8] = byte_at(nn+r*n+c, nn, a_seed, a_step, b_seed, b_step);
      end
    last_b = e.b;
    sb.push_back(e);

    start = 1'b1; size_in = sz; keep_kernel = keep;
    t0 = cycle;
    tick();
    start = 1'b0; keep_kernel = 1'b0;
    chk("busy_after_start", 406'(busy), 406'(1));

    k = 0; budget = 0; v = 1'b0; pulsed = 1'b0;
    while (k < total && budget < 400) begin
      rdy = in_ready;
      v = toggle ? ~v : 1'b1;
      in_valid = v;
      in_data = byte_at(k, nn, a_seed, a_step, b_seed, b_step);
      pulse_now = err_b && !pulsed && (k == nn + 1);
      if (pulse_now) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      start = 1'b0;
      chk(pulse_now ? "err_start_loadb" : "err_start_quiet", 406'(err_start), 406'(pulse_now));
      if (v && rdy) k++;
      budget++;
    end
    in_valid = 1'b0;
    chk("beats_accepted", 406'(k), 406'(total));
    chk("out_valid_rise", 406'(out_valid), 406'(1));
    if (!toggle) chk("latency", 406'(cycle - t0), 406'(1 + total));

    if (sb.size() == 0) begin
      chk("scoreboard_empty", 406'(1), 406'(0));
      return;
    end
    got = sb.pop_front();
    for (int i = 0; i < hold_cyc; i++) begin
      chk("matrix_a", 406'(matrix_a), 406'(got.a));
      chk("matrix_b", 406'(matrix_b), 406'(got.b));
      chk("present_flags", 406'({matrix_size, out_valid, in_ready, busy}),
          406'({got.sz, 3'b101}));
      tick();
    end
    out_ready = 1'b1;
    start = err_hs;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("after_handshake", 406'({out_valid, busy, err_start}), 406'({2'b00, err_hs}));
    tick();
    chk("idle_settled", 406'({out_valid, busy, err_start}), 406'(0));
  endtask

  initial begin
    // Reset state
    tick();
    chk("reset_outputs", {matrix_a, matrix_b, matrix_size, out_valid, in_ready, busy, err_start},
        '0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 406'({out_valid, in_ready, busy, err_start}), 406'(0));

    // 3x3: A = 1..9, B = 0xFF x9
    load(2'b01, 1, 1, 8'hFF, 0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);

    // 2x2 with in_valid toggling and 10 cycles of out_ready low
    load(2'b00, 8'h10, 3, 8'h80, 5, 1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0);

    // Reset after 7 A-beats of a 5x5 load
    start = 1'b1; size_in = 2'b11;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hA0 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("abort_busy", 406'(busy), 406'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {matrix_a, matrix_b, matrix_size, out_valid, in_ready, busy, err_start},
        '0);
    tick();
    rst_n = 1'b1;
    tick();
    load(2'b00, 8'h21, 7, 8'hF0, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // start while busy: during LOAD_B and in the handshake cycle
    load(2'b01, 8'h40, 2, 8'h05, 9, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1);

    // 5x5 full load
    load(2'b11, 8'h03, 1, 8'h81, 3, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);

`ifdef CONV_KERNEL_HOLD_EN
    load(2'b10, 8'h30, 1, 8'hC0, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    load(2'b10, 8'h55, 2, 8'h00, 0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    load(2'b01, 8'h66, 1, 8'h70, 1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
`else
    // keep_kernel must be ignored without the hold feature
    load(2'b10, 8'h30, 1, 8'hC0, 1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
`endif

    chk("scoreboard_drained", 406'(sb.size()), 406'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
